// File: rtl/ex_result_stage.sv
// EX-stage result select and EX/MEM result register, with HI/LO and a sequential radix-2 MULTU.
// Optional MUL_EARLY_EXIT_EN: finish the multiply once the remaining multiplier bits are all zero.
module ex_result_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [WIDTH-1:0]   shift_out,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               stall,
  output logic               out_valid,
  output logic [WIDTH-1:0]   data_out,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out,
  output logic               mul_busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] F_SLL   = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(6'b010000);
  localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(6'b010010);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      counter;

  logic               hilo_class;
  logic               issue;
  logic               mul_start;
  logic               wb_en;
  logic [WIDTH-1:0]   wb_val;
  logic [WIDTH:0]     add_term;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH-1:0] acc_shift;
  logic [2*WIDTH-1:0] product;
  logic               mul_done;

  assign hilo_class = (funct == F_MFHI) || (funct == F_MFLO) || (funct == F_MULTU);
  assign stall      = in_valid && mul_busy && hilo_class;
  assign issue      = in_valid && !stall;
  assign mul_start  = issue && (funct == F_MULTU);

  always_comb begin
    wb_en  = 1'b0;
    wb_val = '0;
    case (funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT: begin
        wb_en  = 1'b1;
        wb_val = alu_out;
      end
      F_SLL: begin
        wb_en  = 1'b1;
        wb_val = shift_out;
      end
      F_MFHI: begin
        wb_en  = 1'b1;
        wb_val = hi_out;
      end
      F_MFLO: begin
        wb_en  = 1'b1;
        wb_val = lo_out;
      end
      default: ;
    endcase
  end

  // Upper half plus multiplicand is WIDTH+1 bits; the carry lands in the top bit
  // and is pulled back inside 2*WIDTH by the right shift.
  assign add_term  = mplier[0] ? {1'b0, mcand} : '0;
  assign upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + add_term;
  assign acc_shift = {upper_sum, acc[WIDTH-1:1]};

`ifdef MUL_EARLY_EXIT_EN
  // Remaining iterations would only shift, so apply the outstanding shift in one go.
  assign mul_done = (counter == CW'(1)) || (mplier[WIDTH-1:1] == '0);
  assign product  = acc_shift >> (counter - CW'(1));
`else
  assign mul_done = (counter == CW'(1));
  assign product  = acc_shift;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      out_valid <= issue && wb_en;
      if (issue && wb_en)
        data_out <= wb_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      counter  <= '0;
      mul_busy <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else if (mul_start) begin
      mcand    <= src_a;
      mplier   <= src_b;
      acc      <= '0;
      counter  <= CW'(WIDTH);
      mul_busy <= 1'b1;
    end else if (mul_busy) begin
      acc     <= acc_shift;
      mplier  <= mplier >> 1;
      counter <= counter - CW'(1);
      if (mul_done) begin
        hi_out   <= product[2*WIDTH-1:WIDTH];
        lo_out   <= product[WIDTH-1:0];
        mul_busy <= 1'b0;
        counter  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ex_result_stage.sv
// Randomised and directed bench for ex_result_stage against a transaction-level model
// (64-bit product, latency countdown, HI/LO hazard rule).
module tb_ex_result_stage;

  localparam int unsigned W = 32;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [5:0]   funct;
  logic [W-1:0] alu_out, shift_out, src_a, src_b;
  logic         stall, out_valid, mul_busy;
  logic [W-1:0] data_out, hi_out, lo_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  bit          m_busy;
  int          m_rem;
  logic [63:0] m_pend;
  logic [31:0] m_hi, m_lo, m_dout;
  bit          m_valid;

  ex_result_stage #(.WIDTH(W), .FUNCT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .funct(funct),
    .alu_out(alu_out), .shift_out(shift_out), .src_a(src_a), .src_b(src_b),
    .stall(stall), .out_valid(out_valid), .data_out(data_out),
    .hi_out(hi_out), .lo_out(lo_out), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mul_latency(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int hb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) hb = i;
    return (hb < 0) ? 1 : hb + 1;
`else
    return 32;
`endif
  endfunction

  function automatic bit is_writeback(input logic [5:0] f);
    return f inside {F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_MFHI, F_MFLO};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_rem = 0; m_pend = '0;
    m_hi = '0; m_lo = '0; m_dout = '0; m_valid = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".busy"},  64'(mul_busy),  64'(m_busy));
    check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".dout"},  64'(data_out),  64'(m_dout));
    check({tag, ".hi"},    64'(hi_out),    64'(m_hi));
    check({tag, ".lo"},    64'(lo_out),    64'(m_lo));
  endtask

  // One pipeline cycle: drive at negedge, check stall, advance the model, check after the edge.
  task automatic step(input bit v, input logic [5:0] f, input logic [31:0] alu,
                      input logic [31:0] sh, input logic [31:0] a, input logic [31:0] b,
                      output bit saw_stall);
    bit exp_stall, iss;
    logic [31:0] sel;
    @(negedge clk);
    in_valid = v; funct = f; alu_out = alu; shift_out = sh; src_a = a; src_b = b;
    #1;
    exp_stall = v && m_busy && (f inside {F_MFHI, F_MFLO, F_MULTU});
    saw_stall = stall;
    check("stall", 64'(stall), 64'(exp_stall));
    iss = v && !exp_stall;
    sel = (f == F_SLL) ? sh : (f == F_MFHI) ? m_hi : (f == F_MFLO) ? m_lo : alu;
    m_valid = iss && is_writeback(f);
    if (m_valid) m_dout = sel;
    if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_hi = m_pend[63:32]; m_lo = m_pend[31:0]; m_busy = 0;
      end
    end
    if (iss && f == F_MULTU) begin
      m_busy = 1; m_rem = mul_latency(b); m_pend = 64'(a) * 64'(b);
    end
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  task automatic idle();
    bit s;
    step(0, F_SLL, $urandom, $urandom, $urandom, $urandom, s);
  endtask

  // Issue MULTU and count the cycles mul_busy stays high afterwards.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input string tag);
    bit s;
    int cyc = 0;
    step(1, F_MULTU, 0, 0, a, b, s);
    while (mul_busy === 1'b1 && cyc < 100) begin
      cyc++;
      idle();
    end
    check({tag, ".lat"}, 64'(cyc), 64'(mul_latency(b)));
    check({tag, ".prod"}, {hi_out, lo_out}, 64'(a) * 64'(b));
  endtask

  initial begin
    bit s;
    int n;
    logic [5:0] fl [10];
    fl = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_MFHI, F_MFLO, F_MULTU, 6'h3F};

    rst_n = 0; in_valid = 0; funct = '0; alu_out = '0; shift_out = '0; src_a = '0; src_b = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk); rst_n = 1;

    // Select paths
    step(1, F_ADD, 32'h12345678, 32'h0, 0, 0, s);
    check("add.dout", 64'(data_out), 64'h12345678);
    step(1, F_SLL, 32'hDEAD, 32'h000000F0, 0, 0, s);
    check("sll.dout", 64'(data_out), 64'hF0);
    step(1, 6'h3F, 32'h1111, 32'h2222, 0, 0, s);
    check("unk.valid", 64'(out_valid), 64'h0);
    check("unk.hold", 64'(data_out), 64'hF0);

    // Worst case
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, "worst");
    check("worst.hi", 64'(hi_out), 64'hFFFFFFFE);
    check("worst.lo", 64'(lo_out), 64'h00000001);

    // HI/LO hazard with concurrent ALU op and blocked second MULTU
    step(1, F_MULTU, 0, 0, 7, 9, s);
    step(1, F_ADD, 32'hA5A5A5A5, 0, 0, 0, s);
    check("conc.nostall", 64'(s), 64'h0);
    step(1, F_MULTU, 0, 0, 100, 100, s);
    check("mul2.stall", 64'(s), 64'h1);
    n = 0;
    s = 1;
    while (s && n < 100) begin
      step(1, F_MFLO, 0, 0, 0, 0, s);
      n++;
    end
    check("mflo.dout", 64'(data_out), 64'd63);
    check("mflo.valid", 64'(out_valid), 64'h1);
    step(1, F_MFHI, 0, 0, 0, 0, s);
    check("mfhi.dout", 64'(data_out), 64'd0);

    // Asynchronous reset mid-multiply
    step(1, F_MULTU, 0, 0, 32'hCAFEBABE, 32'hFFFF0001, s);
    for (int i = 0; i < 9; i++) idle();
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    model_reset();
    check_all("midrst");
    @(negedge clk); rst_n = 1;
    run_mul(3, 5, "after_rst");
    check("after_rst.lo", 64'(lo_out), 64'd15);
    check("after_rst.hi", 64'(hi_out), 64'd0);

    // Latency corner cases (1 and 3 cycles when early exit is built in)
    run_mul(32'h89ABCDEF, 0, "b_zero");
    run_mul(32'h89ABCDEF, 5, "b_five");
    run_mul(32'h80000000, 32'h80000000, "b_top");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] b;
      b = $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
      step($urandom_range(0, 3) != 0, fl[$urandom_range(0, 9)],
           $urandom, $urandom, $urandom, b, s);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/ex_result_stage.md
Name: ex_result_stage

Overview:
- Parametrised, registered successor to the EX-stage writeback result select in the pipelined MIPS-Lite CPU.
- Decodes the R-type funct field and selects among ALU, shifter, HI and LO results, then registers the selection into the EX/MEM boundary.
- Owns the HI/LO registers and a multi-cycle sequential MULTU unit.
- Generates a pipeline stall when a HI/LO consumer, or a second MULTU, arrives while the multiplier is busy.

Parameters:
- WIDTH, 32: datapath width of all operands, results, HI and LO.
- FUNCT_W, 6: width of the funct field.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX stage holds a valid R-type instruction.
- funct  in  FUNCT_W  instruction funct field.
- alu_out  in  WIDTH  ALU result.
- shift_out  in  WIDTH  shifter result.
- src_a  in  WIDTH  MULTU multiplicand (rs value).
- src_b  in  WIDTH  MULTU multiplier (rt value).
- stall  out  1  combinational; hold EX and earlier stages this cycle.
- out_valid  out  1  registered; data_out is a writeback result.
- data_out  out  WIDTH  registered selected result.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.
- mul_busy  out  1  registered; multiply in progress.

Behaviour:
- Reset (async, rst_n low): data_out=0, out_valid=0, hi_out=0, lo_out=0, mul_busy=0, iteration counter=0. An in-flight multiply is aborted and its result is discarded.
- Funct decode (unsigned compare):
  - AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010 -> alu_out.
  - SLL 000000 -> shift_out.
  - MFHI 010000 -> hi_out.
  - MFLO 010010 -> lo_out.
  - MULTU 011001 -> start multiply; no writeback.
  - Any other code -> no writeback.
- stall = in_valid & mul_busy & (funct is MFHI, MFLO or MULTU). ALU/SLL instructions never stall and proceed concurrently with a multiply.
- Issue: an instruction issues on a rising edge when in_valid=1 and stall=0.
- Result register, 1-cycle latency: on issue of a writeback funct, data_out <= selected value and out_valid <= 1.
- On every other edge: out_valid <= 0 and data_out holds its last value. This covers no instruction, stall, MULTU and unknown funct.
- MULTU issue:
  - Latch src_a and src_b; clear the 2*WIDTH product accumulator.
  - counter <= WIDTH; mul_busy <= 1.
  - HI and LO are not modified at issue.
- Iteration (radix-2 shift-add, one multiplier bit per cycle while mul_busy=1):
  - If the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator, with carry into bit 2*WIDTH.
  - Shift right by 1; decrement counter.
- Completion: on the edge where counter reaches 0:
  - hi_out <= product[2W-1:W], lo_out <= product[W-1:0].
  - mul_busy <= 0 on the same edge.
  - Base latency is WIDTH cycles of mul_busy=1.
- Completion-edge behaviour: an MFHI/MFLO presented in the last busy cycle still stalls. On the next cycle it issues and reads the new HI/LO.
- Arithmetic: unsigned throughout; full 2*WIDTH product with no truncation. The carry into the upper half is kept during accumulation.
- Reset mid-multiply: abort immediately per the reset rule above. The next MULTU starts cleanly.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: the multiply completes on the first edge where the remaining shifted multiplier bits are all zero, with the accumulator aligned by the remaining shift count. Latency = max(1, index of highest set bit of src_b + 1) cycles, so src_b=0 completes in 1 cycle. HI/LO values are identical to the non-early result.
- Undefined: latency is always exactly WIDTH cycles.

Test Plan:
- Reset: assert rst_n low during a busy multiply -> data_out=0, out_valid=0, hi_out=lo_out=0, mul_busy=0, all asynchronously.
- ALU and shifter select: issue ADD with alu_out=0x12345678 -> next cycle data_out=0x12345678, out_valid=1. Issue SLL with shift_out=0x000000F0 -> data_out=0xF0. Issue funct 0x3F -> out_valid=0, data_out holds.
- Worst-case multiply: MULTU src_a=src_b=0xFFFFFFFF -> mul_busy=1 for exactly 32 cycles (macro off), then hi_out=0xFFFFFFFE, lo_out=0x00000001.
- HI/LO hazard: MULTU 7*9, then MFLO presented 2 cycles later and held -> stall=1 until mul_busy falls. Next cycle data_out=63, out_valid=1. A concurrent ADD issues with stall=0. A second MULTU during busy stalls.
- Reset mid-operation: rst_n low at cycle 10 of a multiply, released, then MULTU 3*5 -> lo_out=15, hi_out=0. No residue from the aborted operation.
- Early exit (macro on): MULTU src_b=0 -> 1 busy cycle, HI=LO=0. MULTU src_b=0x5 -> 3 busy cycles with the correct product.
